rgmii_rx_framer: RTL and testbench



---
 rtl/rgmii_rx_pkg.sv | 9 +
 rtl/rgmii_rx_inband.sv | 17 +
 rtl/rgmii_rx_framer.sv | 108 ++++++++++
 tb/tb_rgmii_rx_framer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_rx_pkg.sv
// rgmii_rx_pkg: shared state type, framing bytes and speed codes for the RGMII receive framer
package rgmii_rx_pkg;
  typedef enum logic [1:0] {DROP, IDLE, PREAMBLE, DATA} state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [1:0] SPEED_10 = 2'b00;
  localparam logic [1:0] SPEED_100 = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;
endpackage

// File: rtl/rgmii_rx_inband.sv
// rgmii_rx_inband: captures RGMII in-band link status from matching idle nibble pairs
module rgmii_rx_inband (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nib_lo,
  input  logic [3:0] nib_hi,
  input  logic       dv,
  input  logic       er,
  input  logic       idle,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {full_duplex, link_speed, link_up} <= '0;
    else if (idle && !dv && !er && nib_lo == nib_hi) {full_duplex, link_speed, link_up} <= nib_lo;
endmodule

// File: rtl/rgmii_rx_framer.sv
// rgmii_rx_framer: gigabit RGMII receive framer producing an AXI-stream byte flow with
// preamble stripping, length enforcement, error marking and in-band status decode
module rgmii_rx_framer
  import rgmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       rx_ctl_q1,
  input  logic       rx_ctl_q2,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       bad_sfd,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  state_t state;
  logic [7:0] rx_byte, hold;
  logic [15:0] len;
  logic dv, er, err, bad;
  assign rx_byte = {rxd_q2, rxd_q1};
  assign dv = rx_ctl_q1;
  assign er = rx_ctl_q1 ^ rx_ctl_q2;
  assign bad = err || len < MIN_L || len == '0;
  rgmii_rx_inband u_inband (
    .clk(clk),
    .rst_n(rst_n),
    .nib_lo(rxd_q1),
    .nib_hi(rxd_q2),
    .dv(dv),
    .er(er),
    .idle(state == DROP || state == IDLE),
    .link_up(link_up),
    .link_speed(link_speed),
    .full_duplex(full_duplex)
  );
  // len counts bytes already taken into hold, so hold is occupied whenever len != 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= DROP;
      hold <= '0;
      len <= '0;
      err <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      bad_sfd <= 1'b0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      bad_sfd <= 1'b0;
      case (state)
        DROP: if (!dv) state <= IDLE;
        IDLE, PREAMBLE:
          if (!dv) state <= IDLE;
          else if (rx_byte == SFD_BYTE) begin
            state <= DATA;
            len <= '0;
            err <= 1'b0;
          end else if (rx_byte == PREAMBLE_BYTE) state <= PREAMBLE;
          else begin
            bad_sfd <= 1'b1;
            state <= DROP;
          end
        DATA:
          if (dv && len == MAX_L) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= hold;
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= 1'b1;
            frame_err <= 1'b1;
            state <= DROP;
          end else if (dv) begin
            m_axis_tvalid <= len != '0;
            m_axis_tdata <= hold;
            hold <= rx_byte;
            len <= len + 16'd1;
            err <= err | er;
          end else begin
            m_axis_tvalid <= len != '0;
            m_axis_tdata <= hold;
            m_axis_tlast <= len != '0;
            m_axis_tuser <= bad;
            frame_ok <= !bad;
            frame_err <= bad;
            state <= IDLE;
          end
        default: state <= DROP;
      endcase
    end
endmodule

// File: tb/tb_rgmii_rx_framer.sv
// tb_rgmii_rx_framer: randomized frames against a frame-level model, checked by a scoreboard monitor
module tb_rgmii_rx_framer;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  typedef struct {
    logic [7:0] data;
    logic last;
    logic user;
    int cyc;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] rxd_q1 = '0, rxd_q2 = '0;
  logic rx_ctl_q1 = 1'b0, rx_ctl_q2 = 1'b0;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_ok, frame_err, bad_sfd, link_up, full_duplex;
  logic [1:0] link_speed;
  beat_t exp_q[$];
  beat_t mon_b;
  logic [7:0] payload[$];
  logic [3:0] gap_nib = '0;
  int total = 0, bad = 0, cyc = 0;
  int exp_ok = 0, exp_err = 0, exp_bad = 0, act_ok = 0, act_err = 0, act_bad = 0;

  rgmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .rxd_q1(rxd_q1), .rxd_q2(rxd_q2),
    .rx_ctl_q1(rx_ctl_q1), .rx_ctl_q2(rx_ctl_q2),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_ok(frame_ok), .frame_err(frame_err), .bad_sfd(bad_sfd),
    .link_up(link_up), .link_speed(link_speed), .full_duplex(full_duplex)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a byte driven while cyc == k must be on the stream when cyc == k + 2
  always @(negedge clk) if (rst_n) begin
    if (frame_ok) act_ok++;
    if (frame_err) act_err++;
    if (bad_sfd) act_bad++;
    if (m_axis_tvalid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected got data=%h last=%b cyc=%0d, none required", m_axis_tdata, m_axis_tlast, cyc);
      end else begin
        mon_b = exp_q.pop_front();
        if (m_axis_tdata !== mon_b.data || m_axis_tlast !== mon_b.last || cyc != mon_b.cyc ||
            (mon_b.last && m_axis_tuser !== mon_b.user)) begin
          bad++;
          $display("FAIL beat got data=%h last=%b user=%b cyc=%0d required data=%h last=%b user=%b cyc=%0d",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser, cyc, mon_b.data, mon_b.last, mon_b.user, mon_b.cyc);
        end
      end
      if (m_axis_tlast) begin
        total++;
        if (frame_ok !== !m_axis_tuser || frame_err !== m_axis_tuser) begin
          bad++;
          $display("FAIL end_pulse got ok=%b err=%b required ok=%b err=%b", frame_ok, frame_err, !m_axis_tuser, m_axis_tuser);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic e);
    @(negedge clk);
    rxd_q1 = b[3:0];
    rxd_q2 = b[7:4];
    rx_ctl_q1 = v;
    rx_ctl_q2 = v ^ e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive({gap_nib, gap_nib}, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
  endtask

  // frame model: a frame is bad if empty, over MAX_LEN, under MIN_LEN or carrying an error beat;
  // only the first MAX_LEN bytes are delivered
  task automatic send_frame(input int pre, input int er_at, input int gap);
    int n = payload.size();
    bit bad_f = (n == 0) || (n > MAX_LEN) || (n < MIN_LEN) || (er_at >= 0 && er_at < n);
    bit last;
    for (int i = 0; i < pre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(payload[i], 1'b1, i == er_at);
      last = (i == n - 1) || (i == MAX_LEN - 1);
      if (i < MAX_LEN) exp_q.push_back(beat_t'{payload[i], last, bad_f && last, cyc + 2});
    end
    if (bad_f) exp_err++;
    else exp_ok++;
    idle(gap);
  endtask

  task automatic send_bad(input int pre);
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
    for (int i = 0; i < pre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(b, 1'b1, 1'b0);
    exp_bad++;
    drive(8'hD5, 1'b1, 1'b0);
    repeat (4) drive(8'($urandom), 1'b1, 1'b0);
    idle(1);
  endtask

  initial begin
    logic [7:0] d;
    #3;
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tlast", m_axis_tlast, 0);
    chk("reset_pulses", {frame_ok, frame_err, bad_sfd}, 0);
    chk("reset_link", {link_up, link_speed, full_duplex}, 0);
    idle(1);
    rst_n = 1'b1;
    idle(2);
    payload.delete();
    for (int i = 0; i < 64; i++) payload.push_back(8'(i));
    send_frame(7, -1, 2);
    fill_rand(100);
    send_frame(7, 10, 2);
    fill_rand(20);
    send_frame(7, -1, 1);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h5D, 1'b1, 1'b0);
    exp_bad++;
    repeat (3) drive(8'hD5, 1'b1, 1'b0);
    idle(1);
    fill_rand(64);
    send_frame(7, -1, 1);
    fill_rand(1600);
    send_frame(7, -1, 2);
    fill_rand(MAX_LEN);
    send_frame(2, -1, 1);
    fill_rand(0);
    send_frame(3, -1, 1);
    foreach (payload[i]) payload[i] = 8'h00;
    for (int n = 63; n <= 65; n++) begin
      fill_rand(n);
      send_frame(1, -1, 1);
    end
    // reset asserted mid-frame while dv stays high
    for (int i = 0; i < 3; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      drive(d, 1'b1, 1'b0);
      if (i < 8) exp_q.push_back(beat_t'{d, 1'b0, 1'b0, cyc + 2});
    end
    settle();
    chk("pre_reset_tvalid", m_axis_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_tvalid", m_axis_tvalid, 0);
    chk("async_reset_tlast", m_axis_tlast, 0);
    chk("async_reset_tdata", m_axis_tdata, 0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(i % 3 == 2 ? 8'hD5 : 8'h55, 1'b1, 1'b0);
    idle(1);
    fill_rand(70);
    send_frame(5, -1, 2);
    for (int f = 0; f < 60; f++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) send_bad(int'($urandom_range(0, 5)));
      else if (kind == 1) begin
        repeat ($urandom_range(1, 5)) drive(8'h55, 1'b1, 1'b0);
        idle(int'($urandom_range(1, 3)));
      end else begin
        fill_rand(kind == 2 ? 0 : int'($urandom_range(1, 100)));
        send_frame(int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) == 0 ? int'($urandom_range(0, payload.size())) : -1,
                   int'($urandom_range(1, 3)));
      end
    end
    idle(6);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_ok_count", act_ok, exp_ok);
    chk("frame_err_count", act_err, exp_err);
    chk("bad_sfd_count", act_bad, exp_bad);
    gap_nib = 4'hD;
    idle(3);
    settle();
    chk("link_up_d", link_up, 1);
    chk("link_speed_d", link_speed, 2);
    chk("full_duplex_d", full_duplex, 1);
    gap_nib = 4'h2;
    idle(2);
    settle();
    chk("link_status_2", {full_duplex, link_speed, link_up}, 4'h2);
    drive(8'h5D, 1'b0, 1'b0);
    settle();
    chk("link_hold_mismatch", {full_duplex, link_speed, link_up}, 4'h2);
    drive(8'hDD, 1'b0, 1'b1);
    settle();
    chk("link_hold_er", {full_duplex, link_speed, link_up}, 4'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
